muldiv_seq: RTL
===============

# muldiv_seq

Sequential RV32M multiply/divide unit that executes the M-extension ops the single-cycle ALU does not cover in one cycle: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. It sits beside the ALU in the execute stage. It answers requests from the pipeline over a valid/ready request channel and a valid/ready response channel. Results carry a destination tag back so writeback can retire them out of band.

## Interface
- TAG_W, 5, width of the request/response tag (rd index)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort of any in-flight op
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE and rst low)
- req_op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  in  32  rs1 operand
- req_b  in  32  rs2 operand
- req_tag  in  TAG_W  passed through unchanged
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result
- resp_tag  out  TAG_W  tag of the op being returned
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: accept on req_valid && req_ready && !flush. Latch the op and tag. Latch |a| and |b| per op signedness (MULHSU: a signed, b unsigned). Record the result sign. Clear iteration count. Go to CALC.
- Fast-path special cases go IDLE → DONE directly, with the result registered on the accept edge:
  - DIV/DIVU with b==0: 0xFFFFFFFF
  - REM/REMU with b==0: a
  - DIV with a==0x80000000, b==0xFFFFFFFF: 0x80000000
  - REM with that same operand pair: 0
- CALC: one radix-2 iteration per edge, with a 5-bit counter running 0..31. After iteration 31, go to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract into a 32-bit remainder and 32-bit quotient.
- FIX: apply two's-complement negation if the sign flag is set, then select the output.
  - MUL: low 32 bits. MULH*: high 32 bits. DIV*: quotient. REM*: remainder.
  - Remainder sign follows the dividend.
  - Register into resp_data, go to DONE.
- DONE: resp_valid=1; resp_data and resp_tag are held stable. On resp_ready, go to IDLE. No new request is accepted in the same cycle.
- flush (any state): next state is IDLE and resp_valid drops next cycle. A result pending in DONE is discarded. flush beats a same-cycle req_valid.
- rst: state IDLE, resp_valid 0, resp_data 0, resp_tag 0, busy 0, counter 0, req_ready 0 while rst is high. Reset mid-op discards the op.

## Timing
- Accept edge is t0. CALC edges are t1..t32 and the FIX edge is t33. resp_valid is high in the cycle after t33: latency 34 edges, 33 idle cycles.
- Fast path: resp_valid is high the cycle after t0.
- Back-to-back issue: the earliest next accept is the cycle after the resp_ready handshake.
- Holding resp_ready low stalls the unit in DONE indefinitely. Outputs are stable throughout.
- req_ready is combinational from state only, with no path from req_valid.

## Configuration
- MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit combinational multiply registered on the accept edge. The op goes IDLE → DONE with a latency of 1, and CALC/FIX serve division only.
- Undefined: all multiplies use the iterative path with the same 34-edge latency as division. No hardware multiplier is inferred.

## Structure
- Package muldiv_pkg holds:
  - the op encoding constants (MD_MUL..MD_REMU)
  - the state encoding
  - the iteration count constant (32)
  - helpers: is_div(op), is_rem(op), a_signed(op), b_signed(op)
- Sub-module muldiv_iter: a combinational single-iteration datapath. It takes the accumulator/remainder, quotient/multiplier and divisor/multiplicand plus a mode bit, and returns the next values. The top module holds the FSM, registers and sign fix-up.

## Test plan
- DIV a=-7 (0xFFFFFFF9), b=2 → resp_data 0xFFFFFFFD (-3). REM of the same operands → 0xFFFFFFFF (-1). resp_valid exactly 34 edges after accept.
- DIVU a=5, b=0 → 0xFFFFFFFF, and REMU a=5, b=0 → 5, each with resp_valid the cycle after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0; MULHU of the same operands → 0xFFFFFFFE; MULHSU a=-1, b=2 → 0xFFFFFFFF; MUL 0x10000×0x10000 → 0. Run with and without MULDIV_FAST_MUL_EN and check latency 1 vs 34.
- Hold resp_ready low for 10 cycles in DONE → resp_data/resp_tag stable, req_ready low. Then resp_ready=1 → next request accepted one cycle later, with tag 7 returned for tag 7 issued.
- Assert flush at CALC iteration 10 → IDLE next cycle, no resp_valid. A subsequent DIVU 100/7 returns 14 with the correct tag.
- Assert rst during CALC → all outputs at reset values the next cycle. req_ready rises the cycle after rst falls.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and op-classification helpers for the sequential RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam int         MD_ITERS     = 32;
  localparam logic [4:0] MD_LAST_ITER = 5'(MD_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide on magnitudes.
module muldiv_iter
(
  input  logic        div_mode_i,
  input  logic [31:0] acc_i,   // product high half / partial remainder
  input  logic [31:0] aux_i,   // multiplier (shifting out) / dividend -> quotient
  input  logic [31:0] opnd_i,  // multiplicand / divisor
  output logic [31:0] acc_o,
  output logic [31:0] aux_o
);

  logic [32:0] sum;
  logic        ge;
  logic [31:0] diff;

  always_comb begin
    sum   = {1'b0, acc_i} + {1'b0, (aux_i[0] ? opnd_i : 32'd0)};
    // Remainder stays below the divisor, so the shifted value minus divisor fits 32 bits when ge.
    ge    = ({acc_i, aux_i[31]} >= {1'b0, opnd_i});
    diff  = {acc_i[30:0], aux_i[31]} - opnd_i;
    acc_o = sum[32:1];
    aux_o = {sum[0], aux_i[31:1]};
    if (div_mode_i) begin
      if (ge) begin
        acc_o = diff;
        aux_o = {aux_i[30:0], 1'b1};
      end else begin
        acc_o = {acc_i[30:0], aux_i[31]};
        aux_o = {aux_i[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M MUL/MULH*/DIV*/REM* unit with tagged valid/ready request and response.
// Define MULDIV_FAST_MUL_EN to compute all multiplies in one cycle on the accept edge.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int TAG_W = 5
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  md_state_e        state_q, state_d;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      acc_q, aux_q, opnd_q, res_q;
  logic [4:0]       cnt_q;
  logic             neg_q;

  logic        accept, a_neg, b_neg, fast_hit;
  logic [31:0] a_abs, b_abs, fast_val, acc_n, aux_n, div_sel, fix_res;
  logic [63:0] prod_s;

  assign accept = req_valid && req_ready && !flush;
  assign a_neg  = a_signed(req_op) && req_a[31];
  assign b_neg  = b_signed(req_op) && req_b[31];
  assign a_abs  = a_neg ? -req_a : req_a;
  assign b_abs  = b_neg ? -req_b : req_b;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {{32{a_neg}}, req_a} * {{32{b_neg}}, req_b};
`endif

  // Cases resolved on the accept edge without iterating.
  always_comb begin
    fast_hit = 1'b0;
    fast_val = 32'd0;
    if (is_div(req_op)) begin
      if (req_b == 32'd0) begin
        fast_hit = 1'b1;
        fast_val = is_rem(req_op) ? req_a : 32'hFFFF_FFFF;
      end else if ((req_op == MD_DIV || req_op == MD_REM) &&
                   req_a == 32'h8000_0000 && req_b == 32'hFFFF_FFFF) begin
        fast_hit = 1'b1;
        fast_val = is_rem(req_op) ? 32'd0 : 32'h8000_0000;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      fast_hit = 1'b1;
      fast_val = (req_op == MD_MUL) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif
  end

  muldiv_iter u_iter (
    .div_mode_i (is_div(op_q)),
    .acc_i      (acc_q),
    .aux_i      (aux_q),
    .opnd_i     (opnd_q),
    .acc_o      (acc_n),
    .aux_o      (aux_n)
  );

  always_comb begin
    prod_s  = neg_q ? -{acc_q, aux_q} : {acc_q, aux_q};
    div_sel = is_rem(op_q) ? acc_q : aux_q;
    if (is_div(op_q))
      fix_res = neg_q ? -div_sel : div_sel;
    else
      fix_res = (op_q == MD_MUL) ? prod_s[31:0] : prod_s[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = fast_hit ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == MD_LAST_ITER) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !rst;
    busy       = (state_q != ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    resp_data  = res_q;
    resp_tag   = tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= MD_MUL;
      tag_q  <= '0;
      acc_q  <= 32'd0;
      aux_q  <= 32'd0;
      opnd_q <= 32'd0;
      res_q  <= 32'd0;
      cnt_q  <= 5'd0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= req_op;
      tag_q  <= req_tag;
      acc_q  <= 32'd0;
      aux_q  <= a_abs;
      opnd_q <= b_abs;
      cnt_q  <= 5'd0;
      neg_q  <= is_rem(req_op) ? a_neg : (a_neg ^ b_neg);
      if (fast_hit) res_q <= fast_val;
    end else if (state_q == ST_CALC) begin
      acc_q <= acc_n;
      aux_q <= aux_n;
      cnt_q <= cnt_q + 5'd1;
    end else if (state_q == ST_FIX) begin
      res_q <= fix_res;
    end
  end

endmodule
